// File: rtl/audio_pkg.sv
// Shared types and constants for the audio recorder.
// State encoding, sample width and PWM period.
package audio_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  localparam int SAMPLE_W   = 7;
  localparam int PWM_PERIOD = 128;
endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer, one write port.
// Registered read, latency 1, block-RAM friendly.
module sample_ram #(
  parameter int DEPTH = 16384,
  parameter int W     = 7,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/audio_recorder.sv
// Record/playback controller with PWM audio output.
// FSM, address/timing counters and PWM live here.
module audio_recorder
  import audio_pkg::*;
#(
  parameter int DEPTH       = 16384,
  parameter int PLAY_PERIOD = 4167,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] amplitude,
  input  logic                amplitude_valid,
  input  logic                start_record,
  input  logic                start_play,
  input  logic                stop,
  output logic                recording,
  output logic                playing,
  output logic [CW-1:0]       sample_count,
  output logic                play_done,
  output logic                pwm_out,
  output logic                audio_en
);
  localparam int PW = $clog2(PLAY_PERIOD);
  localparam logic [PW-1:0] PC_LAST = PW'(PLAY_PERIOD - 1);
  localparam logic [6:0] PWM_LAST = 7'(PWM_PERIOD - 1);

  state_e state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [6:0] pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0] duty_q, duty_d;
  logic [SAMPLE_W-1:0] sreg_q, sreg_d;
  logic [SAMPLE_W-1:0] rdata;
  logic done_q, done_d;
  logic pwm_q, pwm_d;
  logic rd_pend_q;
  logic we, re, in_play;

  sample_ram #(
    .DEPTH(DEPTH),
    .W    (SAMPLE_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(wr_q),
    .wdata_i(amplitude),
    .re_i   (re),
    .raddr_i(rd_q),
    .rdata_o(rdata)
  );

  // FSM and record/playback address counters.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_record) begin
          state_d = RECORD;
          wr_d    = '0;
          cnt_d   = '0;
        end else if (start_play && cnt_q != '0) begin
          state_d = PLAY;
          rd_d    = '0;
          pc_d    = '0;
        end
      end
      RECORD: begin
        if (amplitude_valid) begin
          we    = 1'b1;
          wr_d  = wr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        if (stop || cnt_d == CW'(DEPTH)) state_d = IDLE;
      end
      PLAY: begin
        re = (pc_q == '0);
        if (stop) begin
          state_d = IDLE;
        end else if (pc_q == PC_LAST) begin
          pc_d = '0;
          if ({1'b0, rd_q} == cnt_q - 1'b1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PWM datapath; everything is held at zero unless playing next.
  always_comb begin
    in_play   = (state_d == PLAY);
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    sreg_d    = sreg_q;
    duty_d    = duty_q;
    if (!in_play) begin
      sreg_d = '0;
      duty_d = '0;
    end else begin
      if (rd_pend_q) sreg_d = rdata;
      if (pwm_cnt_q == PWM_LAST) duty_d = sreg_q;
    end
    pwm_d = in_play && (pwm_cnt_q < duty_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      pc_q      <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      sreg_q    <= '0;
      done_q    <= 1'b0;
      pwm_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      sreg_q    <= sreg_d;
      done_q    <= done_d;
      pwm_q     <= pwm_d;
      rd_pend_q <= re;
    end
  end

  assign recording    = (state_q == RECORD);
  assign playing      = (state_q == PLAY);
  assign audio_en     = (state_q == PLAY);
  assign sample_count = cnt_q;
  assign play_done    = done_q;
  assign pwm_out      = pwm_q;
endmodule

// File: tb/tb_audio_recorder.sv
// Directed self-checking bench for audio_recorder.
// Small buffer and short playback period.
module tb_audio_recorder;
  localparam int DEPTH = 8;
  localparam int PP    = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] amplitude;
  logic       amplitude_valid;
  logic       start_record;
  logic       start_play;
  logic       stop;
  logic       recording;
  logic       playing;
  logic [3:0] sample_count;
  logic       play_done;
  logic       pwm_out;
  logic       audio_en;

  int checks = 0;
  int errors = 0;
  int duty_seq[$];

  always #5 clk = ~clk;

  audio_recorder #(
    .DEPTH      (DEPTH),
    .PLAY_PERIOD(PP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .amplitude      (amplitude),
    .amplitude_valid(amplitude_valid),
    .start_record   (start_record),
    .start_play     (start_play),
    .stop           (stop),
    .recording      (recording),
    .playing        (playing),
    .sample_count   (sample_count),
    .play_done      (play_done),
    .pwm_out        (pwm_out),
    .audio_en       (audio_en)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    amplitude = '0;
    amplitude_valid = 1'b0;
    start_record = 1'b0;
    start_play = 1'b0;
    stop = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_rec();
    start_record = 1'b1;
    step();
    start_record = 1'b0;
  endtask

  task automatic valid(input int v);
    amplitude = 7'(v);
    amplitude_valid = 1'b1;
    step();
    amplitude_valid = 1'b0;
  endtask

  task automatic stop_p();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic run_play(input int wduty, output int ncyc,
                          output int win_hi, output int tot_hi,
                          output int done_end, output int done_after);
    int prev;
    int win;
    int early_done;
    ncyc = 0;
    win_hi = 0;
    tot_hi = 0;
    win = 0;
    prev = 0;
    early_done = 0;
    duty_seq.delete();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    while (playing && ncyc < 4000) begin
      ncyc++;
      tot_hi += int'(pwm_out);
      early_done += int'(play_done);
      if (!audio_en) early_done += 100;
      if (win > 0) begin
        win_hi += int'(pwm_out);
        win--;
      end
      if (int'(dut.duty_q) != prev) begin
        prev = int'(dut.duty_q);
        if (prev != 0) duty_seq.push_back(prev);
        chk("duty_at_wrap", int'(dut.pwm_cnt_q), 0);
        if (prev == wduty) win = 128;
      end
      step();
    end
    chk("no_done_or_en_drop_in_play", early_done, 0);
    done_end = int'(play_done);
    chk("pwm_zero_after_play", int'(pwm_out), 0);
    chk("audio_en_zero_after_play", int'(audio_en), 0);
    step();
    done_after = int'(play_done);
  endtask

  initial begin
    int n, wh, th, de, da, bad;
    do_reset();

    chk("rst_recording", int'(recording), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_audio_en", int'(audio_en), 0);
    chk("rst_done", int'(play_done), 0);

    // basic record of three samples
    start_rec();
    chk("rec_enter", int'(recording), 1);
    valid(10);
    valid(20);
    valid(30);
    chk("rec_count3_pre", int'(sample_count), 3);
    chk("rec_still", int'(recording), 1);
    stop_p();
    chk("rec_exit", int'(recording), 0);
    chk("rec_count3", int'(sample_count), 3);
    chk("ram0", int'(dut.u_ram.mem[0]), 10);
    chk("ram1", int'(dut.u_ram.mem[1]), 20);
    chk("ram2", int'(dut.u_ram.mem[2]), 30);

    // playback of the recording
    run_play(10, n, wh, th, de, da);
    chk("play_len", n, 900);
    chk("play_done_pulse", de, 1);
    chk("play_done_once", da, 0);
    chk("duty_steps", duty_seq.size(), 3);
    if (duty_seq.size() == 3) begin
      chk("duty_0", duty_seq[0], 10);
      chk("duty_1", duty_seq[1], 20);
      chk("duty_2", duty_seq[2], 30);
    end
    chk("pwm_hi_10", wh, 10);
    chk("count_persist", int'(sample_count), 3);

    // overflow: 12 valids into an 8-deep buffer
    start_rec();
    for (int i = 1; i <= 12; i++) begin
      valid(i);
      if (i == 7) chk("ovf_rec7", int'(recording), 1);
      if (i == 8) begin
        chk("ovf_exit", int'(recording), 0);
        chk("ovf_count8", int'(sample_count), 8);
      end
    end
    chk("ovf_count_final", int'(sample_count), 8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (int'(dut.u_ram.mem[i]) != i + 1) bad++;
    chk("ovf_ram_bad_entries", bad, 0);

    // corner commands
    do_reset();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    chk("play_empty_ignored", int'(playing), 0);
    start_record = 1'b1;
    start_play = 1'b1;
    step();
    start_record = 1'b0;
    start_play = 1'b0;
    chk("both_rec", int'(recording), 1);
    chk("both_not_play", int'(playing), 0);
    amplitude = 7'd55;
    amplitude_valid = 1'b1;
    stop = 1'b1;
    step();
    amplitude_valid = 1'b0;
    stop = 1'b0;
    chk("stopv_exit", int'(recording), 0);
    chk("stopv_count", int'(sample_count), 1);
    chk("stopv_ram", int'(dut.u_ram.mem[0]), 55);

    // duty extremes
    start_rec();
    valid(0);
    stop_p();
    run_play(-1, n, wh, th, de, da);
    chk("zero_len", n, 300);
    chk("zero_pwm_hi", th, 0);
    start_rec();
    valid(127);
    stop_p();
    run_play(127, n, wh, th, de, da);
    chk("max_len", n, 300);
    chk("max_pwm_hi", wh, 127);

    // reset in the middle of playback
    start_rec();
    valid(10);
    valid(20);
    valid(30);
    stop_p();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    chk("mid_playing", int'(playing), 1);
    repeat (449) step();
    chk("mid_still_playing", int'(playing), 1);
    rst = 1'b1;
    stop = 1'b1;
    start_record = 1'b1;
    step();
    rst = 1'b0;
    stop = 1'b0;
    start_record = 1'b0;
    chk("mid_rst_playing", int'(playing), 0);
    chk("mid_rst_recording", int'(recording), 0);
    chk("mid_rst_pwm", int'(pwm_out), 0);
    chk("mid_rst_en", int'(audio_en), 0);
    chk("mid_rst_count", int'(sample_count), 0);
    chk("mid_rst_done", int'(play_done), 0);
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    bad = 0;
    repeat (1000) begin
      if (play_done || playing || pwm_out) bad++;
      step();
    end
    chk("post_rst_quiet", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
